// File: rtl/shift_add_multiplier_pkg.sv
// rtl/shift_add_multiplier_pkg.sv - shared constants for the shift-and-add multiplier
package shift_add_multiplier_pkg;

    // Default operand widths, kept in step with the non-restoring divider
    localparam int DEF_WIDTH_A = 32;
    localparam int DEF_WIDTH_B = 16;

    // Controller state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Operation select
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_MAC = 1'b1;

endpackage

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential radix-2 shift-and-add multiplier with optional accumulate
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH_A = DEF_WIDTH_A,
    parameter int WIDTH_B = DEF_WIDTH_B
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_in,
    input  logic                       mode,
    input  logic [WIDTH_A-1:0]         multiplicand,
    input  logic [WIDTH_B-1:0]         multiplier,
    input  logic [WIDTH_A-1:0]         addend,
    output logic                       busy,
    output logic                       valid_out,
    output logic [WIDTH_A+WIDTH_B-1:0] result
);

    localparam int WIDTH_R = WIDTH_A + WIDTH_B;
    localparam int CW      = $clog2(WIDTH_B + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH_B);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    state_e               state_q, state_d;
    logic [WIDTH_R-1:0]   acc_q, acc_d;
    logic [WIDTH_R-1:0]   mc_q, mc_d;
    logic [WIDTH_B-1:0]   mp_q, mp_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic [WIDTH_R-1:0]   result_q, result_d;

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mc_q     <= '0;
            mp_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mc_q     <= mc_d;
            mp_q     <= mp_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    // Next-state: one ADD/SHIFT pair per multiplier bit, no early exit
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_in) state_d = ADD;
            ADD:     state_d = SHIFT;
            SHIFT:   state_d = (cnt_q == CNT_LAST) ? DONE : ADD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values for each state
    always_comb begin
        acc_d    = acc_q;
        mc_d     = mc_q;
        mp_d     = mp_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    // Seeding ACC with the addend makes the accumulate free
                    acc_d  = (mode == MODE_MAC) ? WIDTH_R'(addend) : '0;
                    mc_d   = WIDTH_R'(multiplicand);
                    mp_d   = multiplier;
                    cnt_d  = CNT_INIT;
                    busy_d = 1'b1;
                end
            end
            ADD: begin
                if (mp_q[0]) acc_d = acc_q + mc_q;
            end
            SHIFT: begin
                mc_d  = mc_q << 1;
                mp_d  = mp_q >> 1;
                cnt_d = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) begin
                    result_d = acc_q;
                    valid_d  = 1'b1;
                end
            end
            DONE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                acc_d    = '0;
                mc_d     = '0;
                mp_d     = '0;
                cnt_d    = '0;
                busy_d   = 1'b0;
                valid_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    assign busy      = busy_q;
    assign valid_out = valid_q;
    assign result    = result_q;

    // A result is only ever published while the unit is still busy
    assert property (@(posedge clk) disable iff (reset) valid_q |-> busy_q);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - scoreboard testbench for shift_add_multiplier
module tb_shift_add_multiplier;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic        mode;
    logic [31:0] multiplicand;
    logic [15:0] multiplier;
    logic [31:0] addend;
    logic        busy;
    logic        valid_out;
    logic [47:0] result;

    logic [47:0] exp_q[$];
    int          exp_cyc_q[$];
    int          vectors;
    int          miscompares;
    int          cyc;

    shift_add_multiplier dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .mode         (mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .busy         (busy),
        .valid_out    (valid_out),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Output monitor: every valid_out pulse must match the oldest expectation
    always @(negedge clk) begin
        logic [47:0] e;
        int          c;
        if (reset === 1'b0 && valid_out === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid_out result=%h required no pulse", result);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                if (result !== e) begin
                    miscompares++;
                    $display("FAIL result got=%h required=%h", result, e);
                end
                vectors++;
                if (cyc !== c) begin
                    miscompares++;
                    $display("FAIL latency got_cycle=%0d required_cycle=%0d", cyc, c);
                end
            end
        end
    end

    function automatic logic [47:0] model(input logic m, input logic [31:0] a,
                                          input logic [15:0] b, input logic [31:0] d);
        logic [47:0] p;
        p = {16'd0, a} * {32'd0, b};
        return m ? p + {16'd0, d} : p;
    endfunction

    // Present one request for a single edge, then scramble the operand pins
    task automatic start_op(input logic m, input logic [31:0] a,
                            input logic [15:0] b, input logic [31:0] d);
        @(negedge clk);
        mode         = m;
        multiplicand = a;
        multiplier   = b;
        addend       = d;
        valid_in     = 1'b1;
        exp_q.push_back(model(m, a, b, d));
        exp_cyc_q.push_back(cyc + 33);
        @(negedge clk);
        valid_in     = 1'b0;
        mode         = 1'($urandom);
        multiplicand = $urandom;
        multiplier   = 16'($urandom);
        addend       = $urandom;
    endtask

    // Wait until every expected result has appeared; ends in the DONE cycle
    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({busy, valid_out} !== 2'b00 || result !== 48'd0) begin
            miscompares++;
            $display("FAIL reset_state busy=%b valid=%b result=%h required 0 0 0",
                     busy, valid_out, result);
        end
    endtask

    task automatic test_mac_basic();
        start_op(1'b1, 32'd142, 16'd7, 32'd6);
        vectors++;
        if (busy !== 1'b1 || valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_after_accept busy=%b valid=%b required 1 0", busy, valid_out);
        end
        drain("mac_basic");
        vectors++;
        if (busy !== 1'b1 || result !== 48'd1000) begin
            miscompares++;
            $display("FAIL done_cycle busy=%b result=%0d required 1 1000", busy, result);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL after_done busy=%b valid=%b required 0 0", busy, valid_out);
        end
    endtask

    task automatic test_max_operands();
        start_op(1'b0, 32'hFFFF_FFFF, 16'hFFFF, 32'h0);
        drain("max_mul");
        vectors++;
        if (result !== 48'hFFFE_FFFF_0001) begin
            miscompares++;
            $display("FAIL max_mul got=%h required=fffeffff0001", result);
        end
        start_op(1'b1, 32'hFFFF_FFFF, 16'hFFFF, 32'hFFFF_FFFF);
        drain("max_mac");
        vectors++;
        if (result !== 48'hFFFF_FFFF_0000) begin
            miscompares++;
            $display("FAIL max_mac got=%h required=ffffffff0000", result);
        end
    endtask

    task automatic test_zero_multiplier();
        start_op(1'b1, 32'h1234_5678, 16'd0, 32'hDEAD_BEEF);
        drain("zero_mac");
        start_op(1'b0, 32'h1234_5678, 16'd0, 32'hDEAD_BEEF);
        drain("zero_mul");
    endtask

    task automatic test_ignore_while_busy();
        start_op(1'b0, 32'd5, 16'd3, 32'd0);
        repeat (9) @(negedge clk);
        mode         = 1'b0;
        multiplicand = 32'd9;
        multiplier   = 16'd9;
        valid_in     = 1'b1;
        @(negedge clk);
        valid_in     = 1'b0;
        drain("ignore_busy");
        repeat (6) @(negedge clk);
        vectors++;
        if (result !== 48'd15 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL result_hold got=%0d busy=%b required 15 0", result, busy);
        end
        start_op(1'b0, 32'd1, 16'd1, 32'd0);
        vectors++;
        if (result !== 48'd15) begin
            miscompares++;
            $display("FAIL result_hold_on_accept got=%0d required 15", result);
        end
        drain("hold_next");
    endtask

    task automatic test_reset_mid_op();
        start_op(1'b0, 32'd100, 16'd3, 32'd0);
        repeat (11) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        exp_q.delete();
        exp_cyc_q.delete();
        vectors++;
        if ({busy, valid_out} !== 2'b00 || result !== 48'd0) begin
            miscompares++;
            $display("FAIL reset_mid_op busy=%b valid=%b result=%h required 0 0 0",
                     busy, valid_out, result);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || result !== 48'd0) begin
            miscompares++;
            $display("FAIL after_abort busy=%b result=%h required 0 0", busy, result);
        end
        start_op(1'b0, 32'd2, 16'd2, 32'd0);
        drain("after_reset");
    endtask

    task automatic test_back_to_back();
        logic        m;
        logic [31:0] a, d;
        logic [15:0] b;
        for (int k = 0; k < 3 * 34; k++) begin
            @(negedge clk);
            m = 1'($urandom);
            a = $urandom;
            b = 16'($urandom);
            d = $urandom;
            mode         = m;
            multiplicand = a;
            multiplier   = b;
            addend       = d;
            valid_in     = 1'b1;
            if (k % 34 == 0) begin
                exp_q.push_back(model(m, a, b, d));
                exp_cyc_q.push_back(cyc + 33);
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
        drain("back_to_back");
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        cyc          = 0;
        reset        = 1'b1;
        valid_in     = 1'b0;
        mode         = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        addend       = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_mac_basic();
        test_max_operands();
        test_zero_multiplier();
        test_ignore_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Sequential radix-2 shift-and-add multiplier with an optional accumulate. It computes result = multiplicand × multiplier (+ addend).
It is the inverse datapath of the team's non-restoring divider: quotient × divisor + remainder reconstructs the dividend. It uses the same valid_in / busy / valid_out handshake and sits beside the divider, either in round-trip self-check or as a standalone multiply unit.

Parameters:
WIDTH_A, 32, multiplicand / addend width (quotient width of the divider)
WIDTH_B, 16, multiplier width (divisor width); also the iteration count
WIDTH_R, WIDTH_A+WIDTH_B, result width; derived, not overridable

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
valid_in  in  1  request strobe; sampled only in IDLE
mode  in  1  0: product only; 1: product + addend; latched on accept
multiplicand  in  WIDTH_A  unsigned operand A (divider quotient)
multiplier  in  WIDTH_B  unsigned operand B (divider divisor)
addend  in  WIDTH_A  unsigned accumulate term (divider remainder); used only when mode=1
busy  out  1  operation in progress
valid_out  out  1  one-cycle pulse; result is valid in this cycle
result  out  WIDTH_R  unsigned product or product+addend

Behaviour:
- One clock, clk. reset is asynchronous and active-high.
- All state is registered; no combinational path from inputs to outputs.
- Reset values: state=IDLE, busy=0, valid_out=0, result=0, internal registers and count all 0.
- Internal registers:
  - ACC (WIDTH_R): accumulator
  - MC (WIDTH_R): multiplicand, shifted left each iteration
  - MP (WIDTH_B): multiplier, shifted right each iteration
  - CNT: ceil(log2(WIDTH_B+1)) bits
- States and transitions:
  - IDLE: busy=0. If valid_in=1 at the edge (accept edge E0):
    - ACC <= mode ? zero-extended addend : 0
    - MC <= zero-extended multiplicand; MP <= multiplier; CNT <= WIDTH_B
    - busy <= 1; go to ADD
  - IDLE with valid_in=0: hold.
  - ADD: if MP[0]=1 then ACC <= ACC + MC; go to SHIFT.
  - SHIFT: MC <= MC << 1; MP <= MP >> 1; CNT <= CNT-1.
    - If CNT==1: result <= ACC, valid_out <= 1, go to DONE.
    - Otherwise go to ADD.
  - DONE: valid_out <= 0; busy <= 0; go to IDLE.
  - Unused encodings: return to IDLE with the reset values applied.
- Latency:
  - Fixed 2·WIDTH_B edges from accept to valid_out assertion: 32 edges for the defaults.
  - valid_out is high for exactly one cycle. The next accept is possible at the edge after DONE, giving a throughput of one operation per 2·WIDTH_B+2 cycles.
  - There is no early termination for zero or small operands.
- busy is high from the cycle after E0 through the DONE cycle inclusive.
- valid_in while busy=1 is ignored. There is no queueing and no error flag.
- Operands and mode may change freely after E0; only the latched copies are used.
- result holds its last value until the next completion. It is not cleared on a new accept.
- Width rule: the maximum value (2^WIDTH_A-1)(2^WIDTH_B-1)+(2^WIDTH_A-1) = 2^WIDTH_R - 2^WIDTH_B fits in WIDTH_R. No overflow or carry-out is possible.
- A multiplier of 0 yields the addend (mode=1) or 0 (mode=0), with the same latency.
- Reset mid-operation: immediate return to reset values. No valid_out pulse is produced for the aborted operation.
- valid_in held high continuously: a new operation is accepted every 2·WIDTH_B+2 cycles.

Decomposition:
- Shared package:
  - state encoding constants: IDLE, ADD, SHIFT, DONE, 2 bits
  - default WIDTH_A / WIDTH_B constants, shared with the divider so both stay matched
  - mode encodings: MODE_MUL=0, MODE_MAC=1
- No sub-module. Control and datapath together are small enough for a single module of about 150 lines.

Test Plan:
1. mode=1, multiplicand=142, multiplier=7, addend=6 -> after 32 edges valid_out pulses once, result=1000 (0x3E8), busy falls the following cycle.
2. mode=0, multiplicand=0xFFFFFFFF, multiplier=0xFFFF -> result=0xFFFEFFFF0001. Repeating with mode=1 and addend=0xFFFFFFFF -> result=0xFFFFFFFF0000.
3. mode=1, multiplier=0, multiplicand=0x12345678, addend=0xDEADBEEF -> result=0xDEADBEEF with the full 32-edge latency. With mode=0 the result is 0.
4. Start 5×3 (mode=0), then pulse valid_in with 9×9 at edge 10 while busy -> only result=15 is produced. result stays 15 until the next accepted operation.
5. Start an operation, assert reset at edge 12 -> busy=0, valid_out=0 and result=0 immediately. No pulse follows. A new 2×2 afterwards gives result=4.
6. Hold valid_in=1 with changing operands -> accepts occur every 34 cycles. Each result matches the operands sampled at its own accept edge.
